// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
//   Shares one UART transmit line between two byte-stream requesters and
//   serialises granted bytes as 8N1 frames. A grant is held for a whole packet
//   (up to and including the byte flagged last). Ownership alternates
//   round-robin between packets.
//
// Ports
//   clk12        : clock, all state updates on rising edge
//   rst          : synchronous active-high reset
//   req0_valid   : requester 0 presents a byte
//   req0_data    : byte from requester 0
//   req0_last    : presented byte ends requester 0's packet
//   req0_ready   : byte from requester 0 is accepted this cycle
//   req1_*       : same meanings, for requester 1
//   grant        : one-hot packet owner, 2'b00 when the line is unowned
//   busy         : serialiser is not idle
//   tx           : UART line, idle high
//
// Serialiser states
//   state   | meaning
//   S_IDLE  | line high, ready to accept a byte from the owner
//   S_START | start bit (low), CLKS_PER_BIT cycles
//   S_DATA  | 8 data bits LSB first, CLKS_PER_BIT cycles each
//   S_STOP  | stop bit (high), CLKS_PER_BIT cycles
module uart_tx_arbiter #(
    parameter int CLKS_PER_BIT = 104
) (
    input  logic       clk12,
    input  logic       rst,
    input  logic       req0_valid,
    input  logic [7:0] req0_data,
    input  logic       req0_last,
    output logic       req0_ready,
    input  logic       req1_valid,
    input  logic [7:0] req1_data,
    input  logic       req1_last,
    output logic       req1_ready,
    output logic [1:0] grant,
    output logic       busy,
    output logic       tx
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } ser_state_t;

    ser_state_t       state;
    ser_state_t       state_nxt;
    logic [CNT_W-1:0] baud_cnt;
    logic [3:0]       bit_idx;
    logic [7:0]       shreg;
    logic             prio;

    logic             ser_idle;
    logic             bit_done;
    logic             xfer0;
    logic             xfer1;
    logic             xfer;
    logic             xfer_last;
    logic [7:0]       xfer_data;

    assign ser_idle   = (state == S_IDLE);
    assign bit_done   = (baud_cnt == BAUD_LAST);
    assign req0_ready = grant[0] && ser_idle;
    assign req1_ready = grant[1] && ser_idle;
    assign xfer0      = req0_valid && req0_ready;
    assign xfer1      = req1_valid && req1_ready;
    assign xfer       = xfer0 || xfer1;
    assign xfer_last  = (xfer0 && req0_last) || (xfer1 && req1_last);
    assign xfer_data  = xfer1 ? req1_data : req0_data;

    always_ff @(posedge clk12) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b1;
        tx        = 1'b1;
        case (state)
            S_IDLE: begin
                busy = 1'b0;
                if (xfer) begin
                    state_nxt = S_START;
                end
            end
            S_START: begin
                tx = 1'b0;
                if (bit_done) begin
                    state_nxt = S_DATA;
                end
            end
            S_DATA: begin
                tx = shreg[0];
                if (bit_done && (bit_idx == 4'd7)) begin
                    state_nxt = S_STOP;
                end
            end
            S_STOP: begin
                if (bit_done) begin
                    state_nxt = S_IDLE;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Baud counter and bit index restart on every state entry; within DATA the
    // baud counter also restarts at each bit boundary.
    always_ff @(posedge clk12) begin
        if (rst) begin
            baud_cnt <= '0;
            bit_idx  <= '0;
            shreg    <= 8'hFF;
        end else begin
            if (state_nxt != state) begin
                baud_cnt <= '0;
                bit_idx  <= '0;
            end else if (state != S_IDLE) begin
                if (bit_done) begin
                    baud_cnt <= '0;
                end else begin
                    baud_cnt <= baud_cnt + 1'b1;
                end
                if ((state == S_DATA) && bit_done) begin
                    bit_idx <= bit_idx + 4'd1;
                end
            end

            if (xfer) begin
                shreg <= xfer_data;
            end else if ((state == S_DATA) && bit_done) begin
                shreg <= {1'b1, shreg[7:1]};
            end
        end
    end

    // Arbitration only happens while the line is unowned, so it can overlap
    // the last frame of the previous packet. Release always leaves grant at 0
    // for a cycle before the next owner is chosen.
    always_ff @(posedge clk12) begin
        if (rst) begin
            grant <= 2'b00;
            prio  <= 1'b0;
        end else if (grant == 2'b00) begin
            if (req0_valid && (!req1_valid || !prio)) begin
                grant <= 2'b01;
            end else if (req1_valid) begin
                grant <= 2'b10;
            end
        end else if (xfer_last) begin
            grant <= 2'b00;
            prio  <= grant[0];
        end
    end

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Shares the single UART transmit line between two byte-stream requesters (the CPU response path and the LED/debug status path) and serialises the granted bytes as 8N1 frames. It sits inside `main`, clocked from `clk12`, and drives the board `tx` pin directly. Grants are held for a whole packet, so multi-byte messages from one requester are never interleaved with bytes from the other. Ownership alternates round-robin between packets.

## Interface
Parameters:
- `CLKS_PER_BIT`, default 104: `clk12` cycles per UART bit (12 MHz / 115200). Must be ≥ 2.

Ports:
- `clk12`, input, 1: the only clock; all state updates on its rising edge.
- `rst`, input, 1: synchronous, active-high reset.
- `req0_valid`, input, 1: requester 0 presents a byte.
- `req0_data`, input, 8: byte from requester 0.
- `req0_last`, input, 1: the presented byte ends requester 0's packet.
- `req0_ready`, output, 1: the arbiter accepts a byte from requester 0 this cycle.
- `req1_valid`, `req1_data`, `req1_last`, `req1_ready`: same meanings, for requester 1.
- `grant`, output, 2: one-hot packet owner; `2'b00` when no requester owns the line.
- `busy`, output, 1: the serialiser is not idle.
- `tx`, output, 1: UART line, idle high.

## Operation
- **Transfer.** A byte transfers on any edge where `reqN_valid && reqN_ready`.
- **Ready.** `reqN_ready = grant[N] && ser_idle`. Ready does not depend on valid.
- **Arbitration.**
  - Performed only when `grant == 0`.
  - On an edge with `grant == 0` and at least one valid input, `grant` loads the winner.
  - If only one requester is valid, it wins.
  - If both are valid, the requester selected by the round-robin pointer `prio` wins.
  - Arbitration may occur while the serialiser is still sending the previous packet's last byte.
- **Release.**
  - `grant` clears on the edge that transfers a byte with `last = 1`.
  - On the same edge, `prio` points to the other requester.
- **Lock.** The owner keeps the grant while its valid is low mid-packet. There is no timeout.
- **Serialiser states.** IDLE → START → DATA → STOP → IDLE.
  - Each non-IDLE state lasts `CLKS_PER_BIT` cycles per bit.
  - DATA sends 8 bits, LSB first.
  - A 4-bit bit index and a clog2(`CLKS_PER_BIT`)-bit baud counter reset to 0 on every state entry.
- **Line levels.** `tx` is 0 in START, the data bit in DATA, and 1 in STOP and IDLE.
- **Capture.** The byte is latched into a shift register at transfer. Input data may change afterwards.
- **Busy.** `busy` is 1 in every serialiser state except IDLE.

## Timing
- **Reset values.** `tx = 1`, `grant = 0`, `busy = 0`, both `reqN_ready = 0`, `prio = requester 0`, serialiser IDLE.
- **Reset takes priority** over every other event.
- **Reset mid-frame.** `tx` returns high on the cycle after the reset edge. The partial frame is abandoned and is not resent.
- **First-byte latency.**
  - valid rises before edge 0.
  - `grant` and ready are high after edge 0.
  - The byte transfers at edge 1.
  - `tx` falls after edge 1.
- **Frame length.** `tx` stays low for exactly `CLKS_PER_BIT` cycles, then each data bit for `CLKS_PER_BIT` cycles, then stop high for `CLKS_PER_BIT` cycles. That is 10·`CLKS_PER_BIT` cycles from start to end of stop.
- **Back-to-back bytes.** Ready reasserts on the first IDLE cycle after STOP. With valid held high, the byte-to-byte period is 10·`CLKS_PER_BIT` + 1 cycles.
- **Arbitration overlap.** A new owner may be granted while `busy = 1`. Its ready stays 0 until the serialiser returns to IDLE.
- **Simultaneous events.**
  - Release and a new request in the same cycle: the new grant appears no earlier than the edge after release. `grant` is 0 for at least one cycle between packets.
  - Both requesters rise together after reset: requester 0 wins.
- **Changes while ungranted.** A non-owner's valid or data may change freely; they have no effect.

## Test plan
All scenarios use `CLKS_PER_BIT = 4`.
- **Reset.** Hold `rst` for 3 cycles mid-frame → `tx = 1`, `grant = 0`, `busy = 0` on the following cycle; no further line activity.
- **Single byte.** req0 sends `8'hA5` with last=1 → `tx` shows 0, then 1,0,1,0,0,1,0,1, then 1, each bit 4 cycles (40 cycles total); `grant` returns to 0 after the transfer edge.
- **Packet lock.**
  - Stimulus: req0 sends a 3-byte packet `8'h01`, `8'h02`, `8'h03` (last on the third byte). req1 is valid with `8'hFF` throughout.
  - Required: all three req0 frames appear before req1's byte, and `req1_ready` stays 0 until req0's grant clears.
- **Round-robin.**
  - Stimulus: both requesters send one-byte packets continuously.
  - Required: grant order is 0, 1, 0, 1, and consecutive frames are 41 cycles apart.
- **Stall.**
  - Stimulus: req1 owns the line, then drops valid for 20 cycles mid-packet while req0 is valid.
  - Required: `grant` stays `2'b10`, `tx` stays idle high, and req1's next byte transfers on the first ready edge after valid returns.
- **Data stability.** Change `req0_data` on the cycle after its transfer → the transmitted frame still carries the captured byte.
